// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding selects, hazard FSM states and load/drain constants.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } hz_state_t;

    localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;
    localparam int unsigned DRAIN_CYCLES    = 3;

    // Memory-stage result is newer than writeback, so it wins when both match.
    function automatic fwd_sel_t fwd_pick(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       wr_m,
        input logic       wr_w
    );
        if (wr_m && (rd_m != '0) && (rd_m == rs)) return FWD_MEM;
        if (wr_w && (rd_w != '0) && (rd_w == rs)) return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational operand-forwarding select for both Execute-stage source operands.
module forwarding_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] i_rs1_e,
    input  logic [4:0] i_rs2_e,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic [1:0] o_forward_a,
    output logic [1:0] o_forward_b
);

    assign o_forward_a = fwd_pick(i_rs1_e, i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w);
    assign o_forward_b = fwd_pick(i_rs2_e, i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w);

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard control: load-use stall, branch flush, debug-halt drain FSM
// and saturating stall/flush event counters.
module hazard_scheduler
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1_D,
    input  logic [4:0]  Rs2_D,
    input  logic [4:0]  Rs1_E,
    input  logic [4:0]  Rs2_E,
    input  logic [4:0]  Rd_E,
    input  logic [4:0]  Rd_M,
    input  logic [4:0]  Rd_W,
    input  logic        RegWrite_E,
    input  logic        RegWrite_M,
    input  logic        RegWrite_W,
    input  logic [1:0]  ResultSrc_E,
    input  logic        PCSrc_E,
    input  logic        halt_req,
    output logic        halt_ack,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        Flush_D,
    output logic        Flush_E,
    output logic [1:0]  ForwardA_E,
    output logic [1:0]  ForwardB_E,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    input  logic        cnt_clr
);

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    hz_state_t   r_state;
    logic [1:0]  r_drain_cnt;
    logic        r_halt_ack;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    logic w_lw_stall;
    logic w_stall;
    logic w_flush_d;
    logic w_flush_e;
    logic w_unused;

    assign w_unused = RegWrite_E;

    forwarding_unit u_forwarding_unit (
        .i_rs1_e       (Rs1_E),
        .i_rs2_e       (Rs2_E),
        .i_rd_m        (Rd_M),
        .i_rd_w        (Rd_W),
        .i_reg_write_m (RegWrite_M),
        .i_reg_write_w (RegWrite_W),
        .o_forward_a   (ForwardA_E),
        .o_forward_b   (ForwardB_E)
    );

    assign w_lw_stall = (ResultSrc_E == RESULT_SRC_LOAD) && (Rd_E != '0) &&
                        ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // A taken branch overrides every other stall source so the redirect is never lost.
    always_comb begin
        w_stall   = w_lw_stall;
        w_flush_d = 1'b0;
        w_flush_e = w_lw_stall;
        if (r_state != RUN) begin
            w_stall   = 1'b1;
            w_flush_e = 1'b1;
        end
        if (PCSrc_E) begin
            w_stall   = 1'b0;
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
            r_halt_ack  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (halt_req) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (!halt_req) begin
                        r_state <= RUN;
                    end else if (PCSrc_E) begin
                        r_drain_cnt <= '0;
                    end else if (r_drain_cnt == DRAIN_LAST) begin
                        r_state    <= HALTED;
                        r_halt_ack <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        r_state    <= RUN;
                        r_halt_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_halt_ack <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush_d && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign Stall_F   = w_stall;
    assign Stall_D   = w_stall;
    assign Flush_D   = w_flush_d;
    assign Flush_E   = w_flush_e;
    assign halt_ack  = r_halt_ack;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: vector table, directed halt/reset
// sequences and randomized traffic against a behavioural model.
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic        RegWrite_E, RegWrite_M, RegWrite_W;
    logic [1:0]  ResultSrc_E;
    logic        PCSrc_E, halt_req, halt_ack, cnt_clr;
    logic        Stall_F, Stall_D, Flush_D, Flush_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [31:0] stall_cnt, flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Model: mode 0 = running, 1 = draining, 2 = halted; bubbles already issued.
    int          m_mode;
    int          m_bub;
    logic [31:0] m_sc, m_fc;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww;
        logic [1:0] rse;
        logic       pc;
        logic [7:0] exp;   // {Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_E, ForwardB_E}
    } vec_t;

    vec_t tbl[15];

    hazard_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1_D       (Rs1_D),
        .Rs2_D       (Rs2_D),
        .Rs1_E       (Rs1_E),
        .Rs2_E       (Rs2_E),
        .Rd_E        (Rd_E),
        .Rd_M        (Rd_M),
        .Rd_W        (Rd_W),
        .RegWrite_E  (RegWrite_E),
        .RegWrite_M  (RegWrite_M),
        .RegWrite_W  (RegWrite_W),
        .ResultSrc_E (ResultSrc_E),
        .PCSrc_E     (PCSrc_E),
        .halt_req    (halt_req),
        .halt_ack    (halt_ack),
        .Stall_F     (Stall_F),
        .Stall_D     (Stall_D),
        .Flush_D     (Flush_D),
        .Flush_E     (Flush_E),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .cnt_clr     (cnt_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == rs)) return 2'b10;
        if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == rs)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [8:0] ref_ctrl();
        logic lw, s, fd, fe;
        lw = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
        if (PCSrc_E)          {s, fd, fe} = 3'b011;
        else if (m_mode == 0) {s, fd, fe} = {lw, 1'b0, lw};
        else                  {s, fd, fe} = 3'b101;
        return {s, s, fd, fe, ref_fwd(Rs1_E), ref_fwd(Rs2_E), (m_mode == 2)};
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_E, ForwardB_E, halt_ack};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_bub  = 0;
        m_sc   = 32'd0;
        m_fc   = 32'd0;
    endtask

    task automatic model_tick();
        logic [8:0] e;
        e = ref_ctrl();
        if (cnt_clr) begin
            m_sc = 32'd0;
            m_fc = 32'd0;
        end else begin
            if (e[7] && (m_sc != 32'hFFFF_FFFF)) m_sc = m_sc + 32'd1;
            if (e[6] && (m_fc != 32'hFFFF_FFFF)) m_fc = m_fc + 32'd1;
        end
        case (m_mode)
            0: if (halt_req) begin m_mode = 1; m_bub = 0; end
            1: begin
                if (!halt_req)     m_mode = 0;
                else if (PCSrc_E)  m_bub = 0;
                else if (m_bub + 1 == 3) m_mode = 2;
                else               m_bub = m_bub + 1;
            end
            default: if (!halt_req) m_mode = 0;
        endcase
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step(input string tag);
        #1;
        chk({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(ref_ctrl()));
        chk({tag, ".stall_cnt"}, stall_cnt, m_sc);
        chk({tag, ".flush_cnt"}, flush_cnt, m_fc);
        model_tick();
        @(negedge clk);
    endtask

    task automatic set_idle();
        Rs1_D = 5'd0; Rs2_D = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0;
        Rd_E = 5'd0; Rd_M = 5'd0; Rd_W = 5'd0;
        RegWrite_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
        ResultSrc_E = 2'b00; PCSrc_E = 1'b0; halt_req = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic set_load_use();
        set_idle();
        ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs2_D = 5'd7;
    endtask

    task automatic apply_vec(input vec_t v);
        Rs1_D = v.rs1d; Rs2_D = v.rs2d; Rs1_E = v.rs1e; Rs2_E = v.rs2e;
        Rd_E = v.rde; Rd_M = v.rdm; Rd_W = v.rdw;
        RegWrite_M = v.rwm; RegWrite_W = v.rww; ResultSrc_E = v.rse; PCSrc_E = v.pc;
        halt_req = 1'b0; cnt_clr = 1'b0;
    endtask

    // {Stall_F, Stall_D, Flush_D, Flush_E, halt_ack}
    function automatic logic [4:0] hz();
        return {Stall_F, Stall_D, Flush_D, Flush_E, halt_ack};
    endfunction

    initial begin
        tbl = '{
            '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 2'b00, 1'b0, 8'b0000_10_00},
            '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 2'b00, 1'b0, 8'b0000_01_00},
            '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 2'b00, 1'b0, 8'b0000_01_00},
            '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 1'b1, 1'b0, 2'b00, 1'b0, 8'b0000_00_10},
            '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd4, 5'd9, 1'b1, 1'b1, 2'b00, 1'b0, 8'b0000_00_01},
            '{5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 5'd6, 5'd6, 1'b1, 1'b1, 2'b00, 1'b0, 8'b0000_10_10},
            '{5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 5'd6, 5'd6, 1'b0, 1'b0, 2'b00, 1'b0, 8'b0000_00_00},
            '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 8'b1101_00_00},
            '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 8'b0000_00_00},
            '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 8'b1101_00_00},
            '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 8'b0000_00_00},
            '{5'd7, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 8'b0000_00_00},
            '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b1, 8'b0011_00_00},
            '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 8'b0011_00_00},
            '{5'd3, 5'd4, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 8'b1101_00_00}
        };

        set_idle();
        #1 rst = 1'b0;
        #1;
        chk("rst_halt_ack", 32'(halt_ack), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step("post_rst");

        foreach (tbl[i]) begin
            apply_vec(tbl[i]);
            #1;
            chk($sformatf("tbl%0d", i), 32'(dut_ctrl() >> 1), 32'(tbl[i].exp));
            step($sformatf("tbl%0d", i));
        end

        // Load-use stall bumps stall_cnt by exactly one.
        set_idle(); cnt_clr = 1'b1;
        step("clr");
        set_load_use();
        #1 chk("lw_cnt_before", stall_cnt, 32'd0);
        step("lw");
        set_idle();
        #1 chk("lw_cnt_after", stall_cnt, 32'd1);
        step("lw_idle");

        // Full halt: three bubbles, ack on the fourth cycle, release returns to RUN.
        set_idle(); halt_req = 1'b1;
        step("h_run");
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("h_drain%0d", k), 32'(hz()), 32'b11010);
            step("h_drain");
        end
        #1 chk("h_ack", 32'(hz()), 32'b11011);
        step("h_halted");
        step("h_halted2");
        halt_req = 1'b0;
        step("h_release");
        #1 chk("h_run_again", 32'(hz()), 32'b00000);
        step("h_run_again");

        // Redirect in the second drain cycle restarts the three-bubble drain.
        halt_req = 1'b1;
        step("r_run");
        step("r_drain1");
        PCSrc_E = 1'b1;
        #1 chk("r_redirect", 32'(hz()), 32'b00110);
        step("r_redirect");
        PCSrc_E = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("r_bubble%0d", k), 32'(hz()), 32'b11010);
            step("r_bubble");
        end
        #1 chk("r_ack", 32'(halt_ack), 32'd1);
        step("r_halted");
        halt_req = 1'b0;
        step("r_release");

        // Halt request withdrawn mid-drain: back to RUN, no ack.
        halt_req = 1'b1;
        step("a_run");
        step("a_drain1");
        halt_req = 1'b0;
        step("a_drain2");
        #1 chk("a_back_run", 32'(hz()), 32'b00000);
        step("a_run2");
        #1 chk("a_no_ack", 32'(halt_ack), 32'd0);
        step("a_run3");

        // Saturation of stall_cnt, then clear beats a concurrent stall.
        set_load_use();
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1 release dut.r_stall_cnt;
        m_sc = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) step("sat");
        #1 chk("sat_value", stall_cnt, 32'hFFFF_FFFF);
        cnt_clr = 1'b1;
        step("sat_clr");
        cnt_clr = 1'b0;
        #1 chk("clr_over_stall", stall_cnt, 32'd0);
        step("after_clr");

        // Asynchronous reset while HALTED.
        set_idle(); halt_req = 1'b1;
        for (int k = 0; k < 5; k++) step("x_halt");
        #1 chk("x_halted", 32'(halt_ack), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("x_ack_async", 32'(halt_ack), 32'd0);
        chk("x_scnt_async", stall_cnt, 32'd0);
        chk("x_fcnt_async", flush_cnt, 32'd0);
        model_reset();
        @(negedge clk);
        #1 chk("x_in_reset_run", 32'(hz()), 32'b00000);
        rst = 1'b1;
        step("x_release");
        step("x_drain");
        halt_req = 1'b0;
        step("x_back");

        // Asynchronous reset while DRAINING.
        halt_req = 1'b1;
        step("y_run");
        rst = 1'b0;
        #1 chk("y_reset_run_eq", 32'(hz()), 32'b00000);
        model_reset();
        @(negedge clk);
        halt_req = 1'b0;
        rst = 1'b1;
        step("y_release");

        // Randomized traffic with sticky halt requests.
        set_idle();
        for (int n = 0; n < 3000; n++) begin
            Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
            Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
            Rd_E  = 5'($urandom_range(0, 3)); Rd_M  = 5'($urandom_range(0, 3));
            Rd_W  = 5'($urandom_range(0, 3));
            RegWrite_E = 1'($urandom_range(0, 1));
            RegWrite_M = 1'($urandom_range(0, 1));
            RegWrite_W = 1'($urandom_range(0, 1));
            ResultSrc_E = 2'($urandom_range(0, 3));
            PCSrc_E = ($urandom_range(0, 7) == 0);
            cnt_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, each 5 bits: register indices per stage.
REQ-004 SHALL have inputs RegWrite_E, RegWrite_M, RegWrite_W (1 bit each) and ResultSrc_E (2 bits); ResultSrc_E = 2'b01 marks a load.
REQ-005 SHALL have input PCSrc_E, 1 bit: branch taken or jump resolved in Execute.
REQ-006 SHALL have inputs halt_req (1 bit) and output halt_ack (1 bit): debug halt handshake.
REQ-007 SHALL have outputs Stall_F, Stall_D, Flush_D, Flush_E (1 bit each) and ForwardA_E, ForwardB_E (2 bits each).
REQ-008 SHALL have outputs stall_cnt and flush_cnt (32 bits each) and input cnt_clr (1 bit).

Function
REQ-009 SHALL compute ForwardA_E = 2'b10 when RegWrite_M, Rd_M != 0 and Rd_M == Rs1_E; else 2'b01 when RegWrite_W, Rd_W != 0 and Rd_W == Rs1_E; else 2'b00. ForwardB_E uses Rs2_E the same way. Memory stage has priority.
REQ-010 SHALL assert lw_stall combinationally when ResultSrc_E == 2'b01, Rd_E != 0, and Rd_E matches Rs1_D or Rs2_D.
REQ-011 SHALL implement FSM with states RUN, DRAIN and HALTED.
REQ-012 In RUN:
  - Stall_F = Stall_D = lw_stall.
  - Flush_E = lw_stall | PCSrc_E.
  - Flush_D = PCSrc_E.
REQ-013 Whenever PCSrc_E = 1, in any state, SHALL force Stall_F = 0, Stall_D = 0, Flush_D = 1 and Flush_E = 1 that cycle, so the PC redirect is never lost.
REQ-014 RUN to DRAIN SHALL occur when halt_req = 1; the drain counter loads 0.
REQ-015 In DRAIN, absent PCSrc_E, SHALL drive Stall_F = 1, Stall_D = 1, Flush_E = 1 and Flush_D = 0, and increment the 2-bit drain counter.
REQ-016 DRAIN to HALTED SHALL occur on the cycle the drain counter equals 2 (three bubble cycles); PCSrc_E during DRAIN resets the counter to 0.
REQ-017 In HALTED, SHALL drive Stall_F = 1, Stall_D = 1, Flush_E = 1 and halt_ack = 1 (registered, asserted from the first HALTED cycle).
REQ-018 HALTED to RUN SHALL occur when halt_req = 0; halt_ack deasserts in the same cycle as the RUN entry.
REQ-019 halt_req deasserted during DRAIN SHALL return to RUN next cycle without asserting halt_ack.
REQ-020 stall_cnt SHALL increment on every cycle Stall_D = 1, saturating at 32'hFFFF_FFFF.
REQ-021 flush_cnt SHALL increment on every cycle Flush_D = 1, saturating at 32'hFFFF_FFFF.
REQ-022 cnt_clr SHALL zero both counters synchronously and take priority over increment that cycle.

Reset
REQ-023 On rst = 0, SHALL immediately set state = RUN, drain counter = 0, halt_ack = 0, stall_cnt = 0 and flush_cnt = 0, independent of clk.
REQ-024 During reset, combinational outputs SHALL follow the RUN equations; reset released mid-DRAIN resumes in RUN.

Structure
REQ-025 A shared package pipeline_pkg SHALL hold:
  - enum fwd_sel_t: FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - enum hz_state_t: RUN, DRAIN, HALTED.
  - constant RESULT_SRC_LOAD = 2'b01.
  - constant DRAIN_CYCLES = 3.
REQ-026 Forwarding logic SHALL be one combinational sub-module, forwarding_unit, instantiated once; FSM and counters live in hazard_scheduler.

Verification
REQ-027 Rs1_E = 5, Rd_M = 5, RegWrite_M = 1, Rd_W = 5, RegWrite_W = 1 -> ForwardA_E = 2'b10; same with Rd_M = 0 -> 2'b01.
REQ-028 ResultSrc_E = 2'b01, Rd_E = 7, Rs2_D = 7 -> Stall_F = Stall_D = Flush_E = 1, Flush_D = 0, stall_cnt +1; Rd_E = 0 -> no stall.
REQ-029 halt_req = 1 held -> three cycles of Stall_F/Stall_D/Flush_E, then halt_ack = 1 on cycle 4; drop halt_req -> RUN next cycle, halt_ack = 0.
REQ-030 PCSrc_E = 1 in the second DRAIN cycle -> that cycle Stall_F = 0, Flush_D = 1, Flush_E = 1; halt_ack delayed to three cycles after the redirect.
REQ-031 Preload stall_cnt = 32'hFFFF_FFFE, hold lw_stall for 3 cycles -> saturates at 32'hFFFF_FFFF; cnt_clr = 1 with lw_stall -> 0.
REQ-032 rst = 0 asserted asynchronously mid-HALTED -> halt_ack = 0 and counters = 0 before the next clk edge; state RUN after release.
